// File: rtl/body_rate_controller_pkg.sv
// Shared widths, flags, one-hot state encodings and 16-bit saturation helper
// for the body-rate PID stage.
package body_rate_controller_pkg;

  localparam int RATE_BIT_WIDTH    = 16;
  localparam int OPS_BIT_WIDTH     = 32;
  localparam int FIXED_POINT_SHIFT = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic signed [RATE_BIT_WIDTH-1:0] RATE_MAX = 16'sh7FFF;
  localparam logic signed [RATE_BIT_WIDTH-1:0] RATE_MIN = 16'sh8000;

  typedef enum logic [5:0] {
    WAITING    = 6'b000001,
    CALC_ERROR = 6'b000010,
    CALC_TERMS = 6'b000100,
    SUM        = 6'b001000,
    LIMIT      = 6'b010000,
    COMPLETE   = 6'b100000
  } state_t;

  function automatic logic signed [RATE_BIT_WIDTH-1:0] sat16(
    input logic signed [RATE_BIT_WIDTH:0] v
  );
    if (v > 17'sd32767)       return RATE_MAX;
    else if (v < -17'sd32768) return RATE_MIN;
    else                      return v[RATE_BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/body_rate_controller_rate_pid_axis.sv
// One axis of the body-rate PID: error, P/D(/I) terms, sum and output clamp,
// each stage advanced by its enable. Integrator built only with BODY_RATE_INTEGRAL_EN.
module rate_pid_axis
  import body_rate_controller_pkg::*;
#(
  parameter int KP         = 4,
  parameter int KD         = 2,
  parameter int GAIN_SHIFT = 2,
  parameter int OUT_LIMIT  = 4000,
  parameter int KI         = 1,
  parameter int INT_LIMIT  = 2000
) (
  input  logic                             us_clk,
  input  logic                             resetn,
  input  logic                             en_err,
  input  logic                             en_terms,
  input  logic                             en_sum,
  input  logic                             en_limit,
  input  logic                             int_hold,
  input  logic signed [RATE_BIT_WIDTH-1:0] target,
  input  logic signed [RATE_BIT_WIDTH-1:0] actual,
  output logic signed [RATE_BIT_WIDTH-1:0] axis_out
);

  logic signed [RATE_BIT_WIDTH-1:0] err, prev_err;
  logic signed [RATE_BIT_WIDTH:0]   err_wide;
  logic signed [OPS_BIT_WIDTH-1:0]  err32, prev32;
  logic signed [OPS_BIT_WIDTH-1:0]  p_term, d_term, sum, sum_clamped, i_term;

  assign err_wide = {target[RATE_BIT_WIDTH-1], target} - {actual[RATE_BIT_WIDTH-1], actual};
  assign err32    = OPS_BIT_WIDTH'(err);
  assign prev32   = OPS_BIT_WIDTH'(prev_err);

`ifdef BODY_RATE_INTEGRAL_EN
  logic signed [OPS_BIT_WIDTH-1:0] int_acc, int_next;

  // Anti-windup: clamp the accumulated value, not the increment.
  always_comb begin
    int_next = int_acc + ((err32 * KI) >>> GAIN_SHIFT);
    if (int_next > INT_LIMIT)       int_next = INT_LIMIT;
    else if (int_next < -INT_LIMIT) int_next = -INT_LIMIT;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn)                    int_acc <= '0;
    else if (en_terms && !int_hold) int_acc <= int_next;
  end

  assign i_term = int_acc;
`else
  logic unused_hold;
  assign unused_hold = int_hold;
  assign i_term      = '0;
`endif

  always_comb begin
    sum_clamped = sum;
    if (sum > OUT_LIMIT)       sum_clamped = OUT_LIMIT;
    else if (sum < -OUT_LIMIT) sum_clamped = -OUT_LIMIT;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      err      <= '0;
      prev_err <= '0;
      p_term   <= '0;
      d_term   <= '0;
      sum      <= '0;
      axis_out <= '0;
    end else begin
      if (en_err) err <= sat16(err_wide);
      if (en_terms) begin
        p_term <= (err32 * KP) >>> GAIN_SHIFT;
        d_term <= ((err32 - prev32) * KD) >>> GAIN_SHIFT;
      end
      if (en_sum) begin
        sum      <= p_term + d_term + i_term;
        prev_err <= err;
      end
      if (en_limit) axis_out <= sum_clamped[RATE_BIT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/body_rate_controller.sv
// Body-rate PD/PID controller top: one-hot sequencing FSM, throttle clamp and
// three rate_pid_axis instances. Optional integrator: define BODY_RATE_INTEGRAL_EN.
module body_rate_controller
  import body_rate_controller_pkg::*;
#(
  parameter int PITCH_KP     = 4,
  parameter int ROLL_KP      = 4,
  parameter int YAW_KP       = 4,
  parameter int KD           = 2,
  parameter int GAIN_SHIFT   = 2,
  parameter int OUT_LIMIT    = 4000,
  parameter int THROTTLE_MAX = 4000,
  parameter int KI           = 1,
  parameter int INT_LIMIT    = 2000
) (
  input  logic                             us_clk,
  input  logic                             resetn,
  input  logic                             start_signal,
  input  logic signed [RATE_BIT_WIDTH-1:0] throttle_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] yaw_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] pitch_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] roll_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] yaw_actual,
  input  logic signed [RATE_BIT_WIDTH-1:0] pitch_actual,
  input  logic signed [RATE_BIT_WIDTH-1:0] roll_actual,
  output logic signed [RATE_BIT_WIDTH-1:0] throttle_out,
  output logic signed [RATE_BIT_WIDTH-1:0] yaw_out,
  output logic signed [RATE_BIT_WIDTH-1:0] pitch_out,
  output logic signed [RATE_BIT_WIDTH-1:0] roll_out,
  output logic                             active_signal,
  output logic                             complete_signal
);

  state_t state, state_next;
  logic   active_d, complete_d;
  logic   en_err, en_terms, en_sum, en_limit, int_hold;
  logic signed [RATE_BIT_WIDTH-1:0] throttle_lat;

  // Handshake flags are registered, so they lag the state by one cycle.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= WAITING;
      active_signal   <= FALSE;
      complete_signal <= FALSE;
    end else begin
      state           <= state_next;
      active_signal   <= active_d;
      complete_signal <= complete_d;
    end
  end

  always_comb begin
    state_next = WAITING;
    case (state)
      WAITING:    state_next = start_signal ? CALC_ERROR : WAITING;
      CALC_ERROR: state_next = CALC_TERMS;
      CALC_TERMS: state_next = SUM;
      SUM:        state_next = LIMIT;
      LIMIT:      state_next = COMPLETE;
      COMPLETE:   state_next = WAITING;
      default:    state_next = WAITING;
    endcase
  end

  always_comb begin
    en_err     = (state == CALC_ERROR);
    en_terms   = (state == CALC_TERMS);
    en_sum     = (state == SUM);
    en_limit   = (state == LIMIT);
    active_d   = en_err || en_terms || en_sum || en_limit;
    complete_d = (state == COMPLETE);
  end

  assign int_hold = (throttle_lat <= 16'sd0);

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      throttle_lat <= '0;
      throttle_out <= '0;
    end else begin
      if (en_err) throttle_lat <= throttle_target;
      if (en_limit) begin
        if (throttle_lat < 16'sd0)                            throttle_out <= '0;
        else if (throttle_lat > RATE_BIT_WIDTH'(THROTTLE_MAX)) throttle_out <= RATE_BIT_WIDTH'(THROTTLE_MAX);
        else                                                  throttle_out <= throttle_lat;
      end
    end
  end

  rate_pid_axis #(.KP(YAW_KP), .KD(KD), .GAIN_SHIFT(GAIN_SHIFT), .OUT_LIMIT(OUT_LIMIT),
                  .KI(KI), .INT_LIMIT(INT_LIMIT)) u_yaw (
    .us_clk(us_clk), .resetn(resetn), .en_err(en_err), .en_terms(en_terms),
    .en_sum(en_sum), .en_limit(en_limit), .int_hold(int_hold),
    .target(yaw_target), .actual(yaw_actual), .axis_out(yaw_out)
  );

  rate_pid_axis #(.KP(PITCH_KP), .KD(KD), .GAIN_SHIFT(GAIN_SHIFT), .OUT_LIMIT(OUT_LIMIT),
                  .KI(KI), .INT_LIMIT(INT_LIMIT)) u_pitch (
    .us_clk(us_clk), .resetn(resetn), .en_err(en_err), .en_terms(en_terms),
    .en_sum(en_sum), .en_limit(en_limit), .int_hold(int_hold),
    .target(pitch_target), .actual(pitch_actual), .axis_out(pitch_out)
  );

  rate_pid_axis #(.KP(ROLL_KP), .KD(KD), .GAIN_SHIFT(GAIN_SHIFT), .OUT_LIMIT(OUT_LIMIT),
                  .KI(KI), .INT_LIMIT(INT_LIMIT)) u_roll (
    .us_clk(us_clk), .resetn(resetn), .en_err(en_err), .en_terms(en_terms),
    .en_sum(en_sum), .en_limit(en_limit), .int_hold(int_hold),
    .target(roll_target), .actual(roll_actual), .axis_out(roll_out)
  );

endmodule

// File: tb/tb_body_rate_controller.sv
// Directed self-checking bench for body_rate_controller; expectations follow
// the BODY_RATE_INTEGRAL_EN setting of the build.
module tb_body_rate_controller;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  logic start_signal = 1'b0;
  logic signed [15:0] throttle_target = '0;
  logic signed [15:0] yaw_target = '0, pitch_target = '0, roll_target = '0;
  logic signed [15:0] yaw_actual = '0, pitch_actual = '0, roll_actual = '0;
  logic signed [15:0] throttle_out, yaw_out, pitch_out, roll_out;
  logic active_signal, complete_signal;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 us_clk = ~us_clk;

  body_rate_controller dut (
    .us_clk(us_clk), .resetn(resetn), .start_signal(start_signal),
    .throttle_target(throttle_target),
    .yaw_target(yaw_target), .pitch_target(pitch_target), .roll_target(roll_target),
    .yaw_actual(yaw_actual), .pitch_actual(pitch_actual), .roll_actual(roll_actual),
    .throttle_out(throttle_out), .yaw_out(yaw_out), .pitch_out(pitch_out),
    .roll_out(roll_out), .active_signal(active_signal), .complete_signal(complete_signal)
  );

  task automatic do_reset;
    @(negedge us_clk) resetn = 1'b0;
    @(negedge us_clk) resetn = 1'b1;
  endtask

  // Single-cycle start, then wait (bounded) for complete and one more cycle.
  task automatic run_iter;
    bit seen = 1'b0;
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (complete_signal) seen = 1'b1;
      else @(negedge us_clk);
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("FAIL run_timeout: complete seen=%0d required=1", seen);
    end
    @(negedge us_clk);
  endtask

  task automatic test_reset;
    int n_cmp = 0;
    do_reset();
    #1;
    n_checks++; if (pitch_out !== 16'sd0)    begin n_fails++; $display("FAIL rst_pitch: got %0d expected 0", pitch_out); end
    n_checks++; if (yaw_out !== 16'sd0)      begin n_fails++; $display("FAIL rst_yaw: got %0d expected 0", yaw_out); end
    n_checks++; if (roll_out !== 16'sd0)     begin n_fails++; $display("FAIL rst_roll: got %0d expected 0", roll_out); end
    n_checks++; if (throttle_out !== 16'sd0) begin n_fails++; $display("FAIL rst_throttle: got %0d expected 0", throttle_out); end
    n_checks++; if (active_signal !== 1'b0)  begin n_fails++; $display("FAIL rst_active: got %0d expected 0", active_signal); end
    n_checks++; if (complete_signal !== 1'b0) begin n_fails++; $display("FAIL rst_complete: got %0d expected 0", complete_signal); end
    // Full run so outputs and prev_err are non-zero before the abort.
    pitch_target = 16'sd160; throttle_target = 16'sd1000;
    run_iter();
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    @(negedge us_clk) resetn = 1'b0;   // FSM is in CALC_TERMS here
    #1;
    n_checks++; if (pitch_out !== 16'sd0)    begin n_fails++; $display("FAIL midrst_pitch: got %0d expected 0", pitch_out); end
    n_checks++; if (throttle_out !== 16'sd0) begin n_fails++; $display("FAIL midrst_throttle: got %0d expected 0", throttle_out); end
    @(negedge us_clk) resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge us_clk);
      if (complete_signal) n_cmp++;
    end
    n_checks++; if (n_cmp !== 0) begin n_fails++; $display("FAIL midrst_no_complete: got %0d pulses expected 0", n_cmp); end
  endtask

  task automatic test_pitch;
    int e1, e2;
`ifdef BODY_RATE_INTEGRAL_EN
    e1 = 280; e2 = 240;
`else
    e1 = 240; e2 = 160;
`endif
    pitch_target = 16'sd160; pitch_actual = '0; throttle_target = 16'sd1000;
    run_iter();
    n_checks++; if (pitch_out !== 16'(e1)) begin n_fails++; $display("FAIL pitch_run1: got %0d expected %0d", pitch_out, e1); end
    run_iter();
    n_checks++; if (pitch_out !== 16'(e2)) begin n_fails++; $display("FAIL pitch_run2: got %0d expected %0d", pitch_out, e2); end
  endtask

  task automatic test_saturation;
    pitch_target = '0;
    roll_target = 16'sd1600; roll_actual = -16'sd1600;
    run_iter();
    n_checks++; if (roll_out !== 16'sd4000) begin n_fails++; $display("FAIL roll_sat_pos: got %0d expected 4000", roll_out); end
    roll_target = -16'sd1600; roll_actual = 16'sd1600;
    run_iter();
    n_checks++; if (roll_out !== -16'sd4000) begin n_fails++; $display("FAIL roll_sat_neg: got %0d expected -4000", roll_out); end
    roll_target = '0; roll_actual = '0;
  endtask

  task automatic test_throttle;
    throttle_target = 16'sd4095;
    run_iter();
    n_checks++; if (throttle_out !== 16'sd4000) begin n_fails++; $display("FAIL thr_high: got %0d expected 4000", throttle_out); end
    throttle_target = -16'sd5;
    run_iter();
    n_checks++; if (throttle_out !== 16'sd0) begin n_fails++; $display("FAIL thr_neg: got %0d expected 0", throttle_out); end
    throttle_target = 16'sd1234;
    run_iter();
    n_checks++; if (throttle_out !== 16'sd1234) begin n_fails++; $display("FAIL thr_pass: got %0d expected 1234", throttle_out); end
  endtask

  task automatic test_handshake;
    int n_act = 0, n_cmp = 0, cmp_at = -1;
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge us_clk);
      if (active_signal) n_act++;
      if (complete_signal) begin n_cmp++; cmp_at = k; end
    end
    n_checks++; if (n_act !== 4)  begin n_fails++; $display("FAIL hs_active_len: got %0d expected 4", n_act); end
    n_checks++; if (n_cmp !== 1)  begin n_fails++; $display("FAIL hs_complete_cnt: got %0d expected 1", n_cmp); end
    n_checks++; if (cmp_at !== 5) begin n_fails++; $display("FAIL hs_complete_time: got %0d expected 5", cmp_at); end
    // Second start lands while active and must be dropped.
    n_cmp = 0;
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    @(negedge us_clk);
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (complete_signal) n_cmp++;
      @(negedge us_clk);
    end
    n_checks++; if (n_cmp !== 1) begin n_fails++; $display("FAIL hs_ignore_start: got %0d pulses expected 1", n_cmp); end
  endtask

  task automatic test_back_to_back;
    int n_cmp = 0, first = -1, second = -1;
    @(negedge us_clk) start_signal = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge us_clk);
      if (complete_signal) begin
        n_cmp++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
    end
    start_signal = 1'b0;
    repeat (8) @(negedge us_clk);
    n_checks++; if (n_cmp !== 5)   begin n_fails++; $display("FAIL b2b_count: got %0d expected 5", n_cmp); end
    n_checks++; if (first !== 5)   begin n_fails++; $display("FAIL b2b_first: got %0d expected 5", first); end
    n_checks++; if (second !== 11) begin n_fails++; $display("FAIL b2b_period: got %0d expected 11", second); end
  endtask

`ifdef BODY_RATE_INTEGRAL_EN
  task automatic test_integral;
    int e;
    do_reset();
    yaw_target = 16'sd160; yaw_actual = '0; throttle_target = 16'sd1000;
    for (int r = 1; r <= 55; r++) begin
      run_iter();
      e = 160 + ((r == 1) ? 80 : 0) + ((40 * r > 2000) ? 2000 : 40 * r);
      if (r == 1 || r == 2 || r == 49 || r == 50 || r == 55) begin
        n_checks++;
        if (yaw_out !== 16'(e)) begin n_fails++; $display("FAIL int_run%0d: got %0d expected %0d", r, yaw_out, e); end
      end
    end
    do_reset();
    throttle_target = '0;
    for (int r = 1; r <= 3; r++) begin
      run_iter();
      e = (r == 1) ? 240 : 160;
      n_checks++;
      if (yaw_out !== 16'(e)) begin n_fails++; $display("FAIL int_hold_run%0d: got %0d expected %0d", r, yaw_out, e); end
    end
    yaw_target = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_pitch();
    test_saturation();
    test_throttle();
    test_handshake();
    test_back_to_back();
`ifdef BODY_RATE_INTEGRAL_EN
    test_integral();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/body_rate_controller.md
Name: body_rate_controller

Overview:
- Downstream neighbour of the angle stage. Consumes limited yaw/pitch/roll target rates and throttle, plus IMU body rates.
- Runs one PD (optionally PID) iteration per start pulse. Produces saturated per-axis rate-correction commands for the motor mixer.
- Uses the team start/active/complete handshake. All rate values are 16-bit two's complement, 12.4 fixed point.

Parameters:
- PITCH_KP, 4, pitch proportional gain (integer multiplier)
- ROLL_KP, 4, roll proportional gain
- YAW_KP, 4, yaw proportional gain
- KD, 2, derivative gain, shared by all axes
- GAIN_SHIFT, 2, arithmetic right shift applied after every gain multiply
- OUT_LIMIT, 4000, symmetric saturation for axis outputs (250.0 deg/s)
- THROTTLE_MAX, 4000, throttle upper clamp
- KI, 1, integral gain (INTEGRAL_EN only)
- INT_LIMIT, 2000, integrator clamp magnitude (INTEGRAL_EN only)

Ports:
- us_clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- start_signal  in  1  begin one iteration
- throttle_target  in  16  signed throttle from upstream
- yaw_target / pitch_target / roll_target  in  16 each  signed target rates
- yaw_actual / pitch_actual / roll_actual  in  16 each  signed IMU body rates
- throttle_out  out  16  clamped throttle
- yaw_out / pitch_out / roll_out  out  16 each  saturated PID results
- active_signal  out  1  high while iterating
- complete_signal  out  1  one-cycle pulse when outputs are updated

Behaviour:
- Reset (async, resetn=0): state WAITING; all outputs 0; active/complete 0; prev_err and integrators 0. Reset mid-iteration aborts it and no complete pulse is issued.
- States, one-hot: WAITING -> CALC_ERROR -> CALC_TERMS -> SUM -> LIMIT -> COMPLETE -> WAITING.
- WAITING exits when start_signal is sampled high. Start is ignored while not in WAITING; it is not queued.
- CALC_ERROR:
  - Latch all inputs.
  - err = target - actual, computed at 17 bits, then saturated to 16-bit signed.
- CALC_TERMS:
  - P = (err*KP) >>> GAIN_SHIFT
  - D = ((err - prev_err)*KD) >>> GAIN_SHIFT
  - All computed in 32-bit signed.
- SUM:
  - sum = P + D (+ I), in 32-bit.
  - prev_err <= err.
- LIMIT:
  - Axis outputs = clamp(sum, -OUT_LIMIT, +OUT_LIMIT).
  - throttle_out = clamp(throttle, 0, THROTTLE_MAX).
  - Outputs are registered here and hold until the next LIMIT.
- COMPLETE: complete_signal = 1 for exactly one cycle; active_signal = 0.
- active_signal = 1 in CALC_ERROR through LIMIT inclusive.
- Latency: start sampled at edge N; outputs update at edge N+4; complete_signal is high between edges N+5 and N+6.
- Back-to-back starts: a start held continuously high re-triggers on the cycle the FSM re-enters WAITING (one iteration per 6 cycles).
- Unused/illegal state encodings go to WAITING; outputs are left unchanged.

Optional Feature:
- Macro: BODY_RATE_INTEGRAL_EN.
- Defined:
  - Per-axis integrator int_acc += (err*KI) >>> GAIN_SHIFT in CALC_TERMS, clamped to ±INT_LIMIT (anti-windup).
  - I = int_acc is added in SUM.
  - The integrator is held (not accumulated) while throttle_target <= 0.
- Undefined: no integrator registers are built and sum = P + D.

Decomposition:
- Shared common defines package: RATE_BIT_WIDTH (16), OPS_BIT_WIDTH (32), FIXED_POINT_SHIFT (4), TRUE/FALSE, state encodings, the saturate-to-16 helper constants.
- One sub-module, rate_pid_axis: per-axis err/P/D/I datapath with a stage-enable input. Instantiated three times; the top holds the FSM and the throttle clamp.

Test Plan:
- Reset check: reset asserted mid-iteration (state CALC_TERMS) -> all outputs 0 and no complete pulse. The next start gives first-run D relative to prev_err = 0.
- Pitch first and second run: pitch_target=160 (10.0), actual=0 -> pitch_out=240 on run 1 (P=160, D=80). The same input on run 2 -> pitch_out=160.
- Saturation: roll_target=1600, roll_actual=-1600 -> roll_out=4000. With signs swapped -> roll_out=-4000.
- Throttle clamp: throttle_target=4095 -> 4000; throttle_target=-5 -> 0; throttle_target=1234 -> 1234.
- Handshake timing: a single-cycle start -> active high for 4 cycles, complete pulses once at N+5. A start pulse during active is ignored, so exactly one complete is seen.
- BODY_RATE_INTEGRAL_EN: yaw err=160 held with throttle_target=1000 -> int_acc grows by 40 per run and saturates at 2000. The same test with throttle_target=0 -> int_acc stays constant.
